// File: rtl/cipher_stream_sequencer.sv
// rtl/cipher_stream_sequencer.sv - byte-stream feeder and result register for the A-Z rotor cipher core
module cipher_stream_sequencer #(
    parameter int         STEP_W    = 4,
    parameter int         CNT_W     = 16,
    parameter logic [1:0] RESET_SET = 2'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_load,
    input  logic [1:0]        key_setting,
    input  logic [STEP_W-1:0] step_period,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_char,
    input  logic              in_last,
    output logic [7:0]        core_char,
    output logic [1:0]        core_setting,
    input  logic [7:0]        core_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_char,
    output logic [1:0]        out_setting,
    output logic              out_last,
    output logic [CNT_W-1:0]  char_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [7:0]        hold_char;
    logic              hold_last;
    logic              hold_letter;
    logic [1:0]        key;
    logic [1:0]        setting;
    logic [STEP_W-1:0] period;
    logic [STEP_W-1:0] stepcnt;

    logic       in_is_upper;
    logic       in_is_lower;
    logic [7:0] in_upper;

    assign in_is_upper = (in_char >= 8'h41) && (in_char <= 8'h5a);
    assign in_is_lower = (in_char >= 8'h61) && (in_char <= 8'h7a);
    assign in_upper    = in_is_lower ? (in_char - 8'h20) : in_char;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!key_load && in_valid) state_nxt = S_EVAL;
            S_EVAL:  state_nxt = S_OUT;
            S_OUT:   if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE) && !key_load;
        out_valid = (state == S_OUT);
    end

    // core_char/core_setting are loaded on accept so the core sees them for the whole EVAL cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_char    <= 8'h00;
            hold_last    <= 1'b0;
            hold_letter  <= 1'b0;
            key          <= RESET_SET;
            setting      <= RESET_SET;
            period       <= '0;
            stepcnt      <= '0;
            char_count   <= '0;
            core_char    <= 8'h41;
            core_setting <= RESET_SET;
            out_char     <= 8'h00;
            out_setting  <= RESET_SET;
            out_last     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (key_load) begin
                        key        <= key_setting;
                        period     <= step_period;
                        setting    <= key_setting;
                        stepcnt    <= '0;
                        char_count <= '0;
                    end else if (in_valid) begin
                        hold_char   <= in_char;
                        hold_last   <= in_last;
                        hold_letter <= in_is_upper || in_is_lower;
                        if (in_is_upper || in_is_lower) begin
                            core_char    <= in_upper;
                            core_setting <= setting;
                        end
                    end
                end
                S_EVAL: begin
                    out_last    <= hold_last;
                    out_setting <= setting;
                    if (hold_letter) begin
                        out_char <= core_result;
                        if (char_count != {CNT_W{1'b1}}) begin
                            char_count <= char_count + 1'b1;
                        end
                        // the rotor advances only after this letter has used the current setting
                        if (period != '0) begin
                            if (stepcnt == period - 1'b1) begin
                                setting <= setting + 2'd1;
                                stepcnt <= '0;
                            end else begin
                                stepcnt <= stepcnt + 1'b1;
                            end
                        end
                    end else begin
                        out_char <= hold_char;
                    end
                end
                S_OUT: begin
                    if (out_ready && out_last) begin
                        setting <= key;
                        stepcnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_stream_sequencer.sv
// tb/tb_cipher_stream_sequencer.sv - scoreboard bench for cipher_stream_sequencer
module tb_cipher_stream_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_load;
    logic [1:0]  key_setting;
    logic [3:0]  step_period;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic        in_last;
    logic [7:0]  core_char;
    logic [1:0]  core_setting;
    logic [7:0]  core_result;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_char;
    logic [1:0]  out_setting;
    logic        out_last;
    logic [15:0] char_count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] c;
        logic [1:0] s;
        logic       l;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    cipher_stream_sequencer dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_setting(key_setting),
        .step_period(step_period), .in_valid(in_valid), .in_ready(in_ready),
        .in_char(in_char), .in_last(in_last), .core_char(core_char),
        .core_setting(core_setting), .core_result(core_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_char(out_char), .out_setting(out_setting),
        .out_last(out_last), .char_count(char_count)
    );

    // reciprocal rotor core: index -> (3*setting + 25 - index) mod 26, an involution per setting
    function automatic logic [7:0] core_map(input logic [7:0] c, input logic [1:0] s);
        int idx;
        idx = int'(c) - 65;
        if (idx < 0 || idx > 25) return 8'h3f;
        return 8'(((3 * int'(s) + 25 - idx) % 26) + 65);
    endfunction

    assign core_result = core_map(core_char, core_setting);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {24'h0, out_char}, 32'hffff_ffff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_char", {24'h0, out_char}, {24'h0, e.c});
                chk("out_setting", {30'h0, out_setting}, {30'h0, e.s});
                chk("out_last", {31'h0, out_last}, {31'h0, e.l});
            end
        end
    end

    task automatic push_exp(input logic [7:0] c, input logic [1:0] s, input logic l);
        exp_t e;
        e.c = c; e.s = s; e.l = l;
        sb.push_back(e);
    endtask

    task automatic send(input logic [7:0] c, input logic last);
        bit done = 0;
        in_char  = c;
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                done = 1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) done = 1;
        end
        if (!done) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic load_key(input logic [1:0] k, input logic [3:0] p);
        key_setting = k;
        step_period = p;
        key_load    = 1'b1;
        @(negedge clk);
        key_load    = 1'b0;
    endtask

    task automatic wait_out_valid();
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (out_valid) done = 1;
        end
        if (!done) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; key_load = 1'b0; key_setting = 2'd0; step_period = 4'd0;
        in_valid = 1'b0; in_char = 8'h00; in_last = 1'b0; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_out_char", {24'h0, out_char}, 32'h0);
        chk("rst_out_setting", {30'h0, out_setting}, 32'd0);
        chk("rst_core_char", {24'h0, core_char}, 32'h41);
        chk("rst_core_setting", {30'h0, core_setting}, 32'd0);
        chk("rst_char_count", {16'h0, char_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // key 2, no stepping
        load_key(2'd2, 4'd0);
        push_exp(8'h46, 2'd2, 1'b0); send("A", 1'b0);
        push_exp(8'h45, 2'd2, 1'b1); send("B", 1'b1);
        drain();
        chk("count_t1", {16'h0, char_count}, 32'd2);

        // key 3, step every letter, wraps 3->0
        load_key(2'd3, 4'd1);
        push_exp(core_map("A", 2'd3), 2'd3, 1'b0); send("A", 1'b0);
        push_exp(core_map("A", 2'd0), 2'd0, 1'b0); send("A", 1'b0);
        push_exp(core_map("A", 2'd1), 2'd1, 1'b0); send("A", 1'b0);
        push_exp(core_map("A", 2'd2), 2'd2, 1'b0); send("A", 1'b0);
        push_exp(core_map("A", 2'd3), 2'd3, 1'b1); send("A", 1'b1);
        drain();
        chk("count_t2", {16'h0, char_count}, 32'd5);

        // key 0, period 2, lower case and bypassed punctuation
        load_key(2'd0, 4'd2);
        push_exp(8'h5a, 2'd0, 1'b0); send("a", 1'b0);
        push_exp(8'h20, 2'd0, 1'b0); send(" ", 1'b0);
        push_exp(8'h59, 2'd0, 1'b0); send("b", 1'b0);
        push_exp(8'h21, 2'd1, 1'b0); send("!", 1'b0);
        push_exp(8'h41, 2'd1, 1'b1); send("C", 1'b1);
        drain();
        chk("count_t3", {16'h0, char_count}, 32'd3);

        // downstream stall: outputs stable, in_valid ignored
        out_ready = 1'b0;
        send("Z", 1'b1);
        wait_out_valid();
        in_char = "Q"; in_last = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", {31'h0, out_valid}, 32'd1);
            chk("stall_out_char", {24'h0, out_char}, 32'h41);
            chk("stall_out_setting", {30'h0, out_setting}, 32'd0);
            chk("stall_in_ready", {31'h0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        push_exp(8'h41, 2'd0, 1'b1);
        out_ready = 1'b1;
        drain();

        // same key twice gives identical cipher text; decrypt restores plain text
        load_key(2'd1, 4'd1);
        push_exp(8'h56, 2'd1, 1'b0); send("H", 1'b0);
        push_exp(8'h58, 2'd2, 1'b1); send("I", 1'b1);
        push_exp(8'h56, 2'd1, 1'b0); send("H", 1'b0);
        push_exp(8'h58, 2'd2, 1'b1); send("I", 1'b1);
        push_exp(8'h48, 2'd1, 1'b0); send("V", 1'b0);
        push_exp(8'h49, 2'd2, 1'b1); send("X", 1'b1);
        drain();
        chk("count_t5", {16'h0, char_count}, 32'd6);

        // reset while holding an output
        out_ready = 1'b0;
        send("K", 1'b0);
        wait_out_valid();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("mid_rst_out_char", {24'h0, out_char}, 32'h0);
        chk("mid_rst_out_setting", {30'h0, out_setting}, 32'd0);
        chk("mid_rst_core_char", {24'h0, core_char}, 32'h41);
        chk("mid_rst_count", {16'h0, char_count}, 32'd0);
        chk("mid_rst_in_ready", {31'h0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        key_setting = 2'd3; step_period = 4'd0; key_load = 1'b1;
        in_char = "M"; in_last = 1'b1; in_valid = 1'b1;
        #1;
        chk("keyload_in_ready", {31'h0, in_ready}, 32'd0);
        @(negedge clk);
        key_load = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("keyload_no_accept", {31'h0, out_valid}, 32'd0);
            @(negedge clk);
        end
        push_exp(8'h49, 2'd3, 1'b1); send("A", 1'b1);
        drain();
        chk("count_t6", {16'h0, char_count}, 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
        $fatal(1, "timeout");
    end

endmodule
